// File: rtl/dac_spi_core.sv
// Maps a 32-bit control word to a DAC code (center/gain/zero) and ships it to a
// dual-channel SPI DAC as a 16-bit frame followed by an LDAC pulse.
module dac_spi_core #(
  parameter int unsigned DAC_WIDTH = 12,
  parameter int unsigned SCLK_DIV  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        param_wen,
  input  logic [31:0] dac_center,
  input  logic [31:0] dac_kf,
  input  logic [31:0] dac_zero_cal,
  input  logic [31:0] dac_ch_sel,
  input  logic        value_valid,
  input  logic [31:0] value,
  output logic        value_ready,
  output logic        busy,
  output logic        sat_flag,
  output logic        dac_csn,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        dac_ldacn
);

  localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);
  localparam logic signed [49:0] CodeMax = 50'((1 << DAC_WIDTH) - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StShift, StLoad} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            center_q, center_d;
  logic [31:0]            kf_q, kf_d;
  logic [31:0]            zero_q, zero_d;
  logic [31:0]            ch_q, ch_d;
  logic [31:0]            value_q, value_d;
  logic                   neg_q, neg_d;
  logic [31:0]            diff_q, diff_d;
  logic [47:0]            scaled_q, scaled_d;
  logic [DAC_WIDTH-1:0]   code_q, code_d;
  logic                   sat_q, sat_d;
  logic [1:0]             step_q, step_d;
  logic [DivW-1:0]        div_q, div_d;
  logic [3:0]             bit_q, bit_d;
  logic [15:0]            shreg_q, shreg_d;
  logic                   csn_q, csn_d;
  logic                   sclk_q, sclk_d;
  logic                   sdi_q, sdi_d;
  logic                   ldacn_q, ldacn_d;

  logic                   accept;
  logic                   ch_valid;
  logic [63:0]            prod;
  logic signed [49:0]     zc_ext;
  logic signed [49:0]     sc_ext;
  logic signed [49:0]     sum;
  logic [11:0]            code12;
  logic [15:0]            frame;

  assign value_ready = rstn && (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign sat_flag    = sat_q;
  assign dac_csn     = csn_q;
  assign dac_sclk    = sclk_q;
  assign dac_sdi     = sdi_q;
  assign dac_ldacn   = ldacn_q;

  assign accept   = value_valid && value_ready;
  assign ch_valid = (ch_q == 32'd1) || (ch_q == 32'd2);

  assign prod   = 64'(diff_q) * 64'(kf_q);
  assign zc_ext = signed'({18'b0, zero_q});
  assign sc_ext = signed'({2'b0, scaled_q});
  assign sum    = neg_q ? (zc_ext - sc_ext) : (zc_ext + sc_ext);

  // Narrow DACs are left-justified in the 12-bit code field.
  assign code12 = 12'(code_q) << (12 - DAC_WIDTH);
  assign frame  = {((ch_q == 32'd1) ? 2'b01 : 2'b10), 2'b00, code12};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      center_q <= '0;
      kf_q     <= '0;
      zero_q   <= '0;
      ch_q     <= '0;
      value_q  <= '0;
      neg_q    <= 1'b0;
      diff_q   <= '0;
      scaled_q <= '0;
      code_q   <= '0;
      sat_q    <= 1'b0;
      step_q   <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      sdi_q    <= 1'b0;
      ldacn_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      center_q <= center_d;
      kf_q     <= kf_d;
      zero_q   <= zero_d;
      ch_q     <= ch_d;
      value_q  <= value_d;
      neg_q    <= neg_d;
      diff_q   <= diff_d;
      scaled_q <= scaled_d;
      code_q   <= code_d;
      sat_q    <= sat_d;
      step_q   <= step_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      sdi_q    <= sdi_d;
      ldacn_q  <= ldacn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    center_d = center_q;
    kf_d     = kf_q;
    zero_d   = zero_q;
    ch_d     = ch_q;
    value_d  = value_q;
    neg_d    = neg_q;
    diff_d   = diff_q;
    scaled_d = scaled_q;
    code_d   = code_q;
    sat_d    = sat_q;
    step_d   = step_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    csn_d    = csn_q;
    sclk_d   = sclk_q;
    sdi_d    = sdi_q;
    ldacn_d  = ldacn_q;

    unique case (state_q)
      StIdle: begin
        if (param_wen) begin
          center_d = dac_center;
          kf_d     = dac_kf;
          zero_d   = dac_zero_cal;
          ch_d     = dac_ch_sel;
        end
        if (accept) begin
          value_d = value;
          step_d  = '0;
          state_d = StCalc;
        end
      end

      // Steps 0..2 are the c1..c3 pipeline; step 3 stages the frame.
      StCalc: begin
        step_d = step_q + 2'd1;
        unique case (step_q)
          2'd0: begin
            neg_d  = value_q < center_q;
            diff_d = (value_q < center_q) ? (center_q - value_q) : (value_q - center_q);
          end
          2'd1: scaled_d = 48'(prod >> 16);
          2'd2: begin
            if (sum < 50'sd0) begin
              code_d = '0;
              sat_d  = 1'b1;
            end else if (sum > CodeMax) begin
              code_d = '1;
              sat_d  = 1'b1;
            end else begin
              code_d = sum[DAC_WIDTH-1:0];
              sat_d  = 1'b0;
            end
          end
          default: begin
            if (ch_valid) begin
              state_d = StShift;
              shreg_d = frame;
              csn_d   = 1'b0;
              sclk_d  = 1'b0;
              sdi_d   = frame[15];
              div_d   = '0;
              bit_d   = 4'd15;
            end else begin
              state_d = StIdle;
            end
          end
        endcase
      end

      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              csn_d   = 1'b1;
              sdi_d   = 1'b0;
              ldacn_d = 1'b0;
              state_d = StLoad;
            end else begin
              bit_d   = bit_q - 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
              sdi_d   = shreg_q[14];
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      StLoad: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          ldacn_d = 1'b1;
          state_d = StIdle;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_core.sv
// Directed bench for dac_spi_core: expected frames/sat are queued at accept and
// compared when the DUT completes the SPI frame.
module tb_dac_spi_core;

  logic        clk;
  logic        rstn;
  logic        param_wen;
  logic [31:0] dac_center;
  logic [31:0] dac_kf;
  logic [31:0] dac_zero_cal;
  logic [31:0] dac_ch_sel;
  logic        value_valid;
  logic [31:0] value;
  logic        value_ready;
  logic        busy;
  logic        sat_flag;
  logic        dac_csn;
  logic        dac_sclk;
  logic        dac_sdi;
  logic        dac_ldacn;

  int n_asserts = 0;
  int n_fails   = 0;
  logic [16:0] exp_q[$];

  localparam logic [31:0] Center = 32'h1000_0000;

  dac_spi_core #(
    .DAC_WIDTH(12),
    .SCLK_DIV (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .param_wen   (param_wen),
    .dac_center  (dac_center),
    .dac_kf      (dac_kf),
    .dac_zero_cal(dac_zero_cal),
    .dac_ch_sel  (dac_ch_sel),
    .value_valid (value_valid),
    .value       (value),
    .value_ready (value_ready),
    .busy        (busy),
    .sat_flag    (sat_flag),
    .dac_csn     (dac_csn),
    .dac_sclk    (dac_sclk),
    .dac_sdi     (dac_sdi),
    .dac_ldacn   (dac_ldacn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [31:0] c, input logic [31:0] k, input logic [31:0] z,
                      input logic [31:0] ch);
    dac_center   = c;
    dac_kf       = k;
    dac_zero_cal = z;
    dac_ch_sel   = ch;
    param_wen    = 1'b1;
    @(negedge clk);
    param_wen = 1'b0;
  endtask

  // Present a word at a negedge; returns one negedge after the accept edge.
  task automatic start_word(input logic [31:0] v, input logic [15:0] fr, input logic sat,
                            input bit push, input bit hold);
    check("ready_before_accept", 32'(value_ready), 32'd1);
    value_valid = 1'b1;
    value       = v;
    if (push) exp_q.push_back({sat, fr});
    @(negedge clk);
    if (!hold) value_valid = 1'b0;
  endtask

  // Watches the pins until value_ready returns; pwen_cyc >= 0 pulses param_wen mid-frame.
  task automatic run_frame(input string tag, input bit drop, input int pwen_cyc);
    logic [15:0] shin;
    logic [16:0] exp;
    logic        p_sclk, p_sdi, p_csn;
    logic [31:0] s_c, s_k, s_z, s_ch;
    int nbits, csn_fall, csn_rise, ld_lo, ready_cyc, sdi_bad, cyc;
    shin = '0; nbits = 0; ld_lo = 0; sdi_bad = 0; cyc = 0;
    csn_fall = -1; csn_rise = -1; ready_cyc = -1;
    p_sclk = dac_sclk; p_sdi = dac_sdi; p_csn = dac_csn;
    s_c = dac_center; s_k = dac_kf; s_z = dac_zero_cal; s_ch = dac_ch_sel;
    while (ready_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == pwen_cyc) begin
        dac_center = 32'h0; dac_kf = 32'h0002_0000; dac_zero_cal = 32'd0; dac_ch_sel = 32'd2;
        param_wen = 1'b1;
      end else if (pwen_cyc >= 0 && cyc == pwen_cyc + 1) begin
        param_wen = 1'b0;
        dac_center = s_c; dac_kf = s_k; dac_zero_cal = s_z; dac_ch_sel = s_ch;
      end
      if (p_csn && !dac_csn && csn_fall < 0) csn_fall = cyc;
      if (!p_csn && dac_csn) csn_rise = cyc;
      if (!p_sclk && dac_sclk) begin
        shin = {shin[14:0], dac_sdi};
        nbits++;
      end
      if (dac_sdi !== p_sdi && !(p_sclk && !dac_sclk) && !(p_csn && !dac_csn)) sdi_bad++;
      if (!dac_ldacn) ld_lo++;
      if (value_ready) ready_cyc = cyc;
      p_sclk = dac_sclk; p_sdi = dac_sdi; p_csn = dac_csn;
    end
    if (drop) begin
      check({tag, "_drop_ready_lat"}, 32'(ready_cyc), 32'd4);
      check({tag, "_drop_csn"}, 32'(csn_fall), 32'hffff_ffff);
      check({tag, "_drop_sclk_bits"}, 32'(nbits), 32'd0);
      check({tag, "_drop_ldacn"}, 32'(ld_lo), 32'd0);
    end else begin
      check({tag, "_csn_fall_lat"}, 32'(csn_fall), 32'd4);
      check({tag, "_csn_low_len"}, 32'(csn_rise - csn_fall), 32'd128);
      check({tag, "_nbits"}, 32'(nbits), 32'd16);
      check({tag, "_sdi_timing"}, 32'(sdi_bad), 32'd0);
      check({tag, "_ldacn_len"}, 32'(ld_lo), 32'd4);
      check({tag, "_ready_lat"}, 32'(ready_cyc), 32'd136);
      if (exp_q.size() == 0) begin
        check({tag, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check({tag, "_frame"}, 32'(shin), 32'(exp[15:0]));
        check({tag, "_sat"}, 32'(sat_flag), 32'(exp[16]));
      end
    end
  endtask

  initial begin
    logic [16:0] junk;
    int rises;
    rstn = 1'b0; param_wen = 1'b0; value_valid = 1'b0; value = '0;
    dac_center = '0; dac_kf = '0; dac_zero_cal = '0; dac_ch_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_csn", 32'(dac_csn), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd0);
    check("rst_sdi", 32'(dac_sdi), 32'd0);
    check("rst_ldacn", 32'(dac_ldacn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_ready", 32'(value_ready), 32'd0);
    rstn = 1'b1;
    #1 check("ready_after_rst", 32'(value_ready), 32'd1);
    @(negedge clk);

    prog(Center, 32'h0001_0000, 32'd2048, 32'd1);
    start_word(32'h1000_0064, 16'h4864, 1'b0, 1'b1, 1'b0);
    run_frame("pos", 1'b0, -1);

    prog(Center, 32'h0001_0000, 32'd2048, 32'd2);
    start_word(32'h0FFF_FF00, 16'h8700, 1'b0, 1'b1, 1'b0);
    run_frame("neg", 1'b0, -1);

    prog(Center, 32'h0001_0000, 32'd2048, 32'd1);
    start_word(Center + 32'h10000, 16'h4FFF, 1'b1, 1'b1, 1'b0);
    run_frame("sat_hi", 1'b0, -1);
    start_word(Center - 32'h10000, 16'h4000, 1'b1, 1'b1, 1'b0);
    run_frame("sat_lo", 1'b0, -1);
    start_word(Center + 32'd100, 16'h4864, 1'b0, 1'b1, 1'b0);
    run_frame("sat_clear", 1'b0, -1);

    // New gain written in the same cycle as the accept must apply to that word.
    dac_kf    = 32'h0000_8000;
    param_wen = 1'b1;
    start_word(Center + 32'd200, 16'h4864, 1'b0, 1'b1, 1'b0);
    param_wen = 1'b0;
    run_frame("gain", 1'b0, -1);

    prog(Center, 32'h0000_8000, 32'd2048, 32'd0);
    start_word(Center + 32'd200, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_frame("chsel0", 1'b1, -1);

    prog(Center, 32'h0001_0000, 32'd2048, 32'd1);
    start_word(32'h1000_0064, 16'h4864, 1'b0, 1'b1, 1'b0);
    rises = 0;
    for (int i = 0; i < 400 && rises < 5; i++) begin
      logic ps;
      ps = dac_sclk;
      @(negedge clk);
      if (!ps && dac_sclk) rises++;
    end
    check("rst_mid_bits_seen", 32'(rises), 32'd5);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_mid_csn", 32'(dac_csn), 32'd1);
    check("rst_mid_sclk", 32'(dac_sclk), 32'd0);
    check("rst_mid_ldacn", 32'(dac_ldacn), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready_low", 32'(value_ready), 32'd0);
    if (exp_q.size() > 0) junk = exp_q.pop_front();
    rstn = 1'b1;
    #1 check("rst_mid_ready_high", 32'(value_ready), 32'd1);
    @(negedge clk);
    prog(Center, 32'h0001_0000, 32'd2048, 32'd1);
    start_word(32'h1000_0064, 16'h4864, 1'b0, 1'b1, 1'b0);
    run_frame("post_rst", 1'b0, -1);

    // value_valid held high: one accept per transaction; mid-frame param_wen ignored.
    start_word(32'h1000_0064, 16'h4864, 1'b0, 1'b1, 1'b1);
    run_frame("stress1", 1'b0, 50);
    start_word(32'h1000_0064, 16'h4864, 1'b0, 1'b1, 1'b1);
    value_valid = 1'b0;
    run_frame("stress2", 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
